// File: rtl/disp_sched.sv
// disp_sched: scan-rate enable and digit source selection for the four-digit
// seven-segment scan driver. The live counter is shown with leading-zero
// blanking, refreshed once per scan frame. A one-shot message, accepted over
// a req/ack handshake, pre-empts the count for MSG_HOLD scan ticks and is then
// followed by GAP_TICKS ticks of blank.
// Optional feature: define DISP_BLINK_EN to blink the message (32 ticks on,
// 32 ticks off) while it is being shown.
module disp_sched #(
   parameter int SCAN_DIV  = 1000,
   parameter int MSG_HOLD  = 256,
   parameter int GAP_TICKS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cnt_val,
   input  logic        msg_req,
   input  logic [15:0] msg_data,
   output logic        msg_ack,
   output logic        scan_tick,
   output logic [3:0]  d4,
   output logic [3:0]  d3,
   output logic [3:0]  d2,
   output logic [3:0]  d1
);

   localparam int PW   = $clog2(SCAN_DIV);
   localparam int HMAX = (MSG_HOLD > GAP_TICKS) ? MSG_HOLD : GAP_TICKS;
   localparam int HW   = $clog2(HMAX + 1);

   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] PRESC_PRE  = PW'(SCAN_DIV - 2);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(MSG_HOLD - 1);
   localparam logic [HW-1:0] GAP_LAST   = HW'(GAP_TICKS - 1);
   localparam logic [15:0]   ALL_BLANK  = 16'hFFFF;

   typedef enum logic [1:0] {CNT, MSG_SHOW, MSG_GAP} state_t;

   state_t        state;
   logic [PW-1:0] presc;
   logic [1:0]    frame;
   logic [HW-1:0] hold;
   logic [15:0]   digits;
   logic          frameEnd;

`ifdef DISP_BLINK_EN
   logic [5:0]    blinkCnt;
   logic [5:0]    blinkNext;
   logic [15:0]   msgReg;

   assign blinkNext = blinkCnt + 6'd1;
`endif

   assign {d4, d3, d2, d1} = digits;

   // scan_tick is registered one cycle early so it is high exactly while
   // the prescaler sits at its terminal count; it then doubles as the tick.
   assign frameEnd = scan_tick && (frame == 2'd3);

   // Leading-zero blanking: a digit blanks only if it and every higher digit
   // are zero. d1 always shows; non-BCD nibbles pass through untouched.
   function automatic logic [15:0] blankLz(input logic [15:0] v);
      logic [15:0] r;
      r = v;
      if (v[15:12] == 4'd0) r[15:12] = 4'hF;
      if (v[15:8]  == 8'd0) r[11:8]  = 4'hF;
      if (v[15:4]  == 12'd0) r[7:4]  = 4'hF;
      return r;
   endfunction

   // Free-running prescaler and scan tick, independent of the FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc     <= '0;
         scan_tick <= 1'b0;
      end else begin
         scan_tick <= (presc == PRESC_PRE);
         presc     <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
      end
   end

   // Frame counter: four ticks per frame, wraps freely.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) frame <= 2'd0;
      else if (scan_tick) frame <= frame + 2'd1;
   end

   // Display FSM: count refresh, message accept, hold and blank gap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= CNT;
         hold     <= '0;
         digits   <= ALL_BLANK;
         msg_ack  <= 1'b0;
`ifdef DISP_BLINK_EN
         blinkCnt <= 6'd0;
         msgReg   <= ALL_BLANK;
`endif
      end else begin
         msg_ack <= 1'b0;
         case (state)
            CNT: begin
               // a request beats a coincident frame boundary
               if (msg_req) begin
                  digits   <= msg_data;
                  msg_ack  <= 1'b1;
                  hold     <= '0;
                  state    <= MSG_SHOW;
`ifdef DISP_BLINK_EN
                  blinkCnt <= 6'd0;
                  msgReg   <= msg_data;
`endif
               end else if (frameEnd) begin
                  digits <= blankLz(cnt_val);
               end
            end
            MSG_SHOW: begin
               if (scan_tick) begin
                  if (hold == HOLD_LAST) begin
                     digits <= ALL_BLANK;
                     hold   <= '0;
                     state  <= MSG_GAP;
                  end else begin
                     hold <= hold + 1'b1;
`ifdef DISP_BLINK_EN
                     blinkCnt <= blinkNext;
                     digits   <= blinkNext[5] ? ALL_BLANK : msgReg;
`endif
                  end
               end
            end
            MSG_GAP: begin
               if (scan_tick) begin
                  if (hold == GAP_LAST) begin
                     // reload immediately rather than waiting for a frame
                     digits <= blankLz(cnt_val);
                     hold   <= '0;
                     state  <= CNT;
                  end else begin
                     hold <= hold + 1'b1;
                  end
               end
            end
            default: begin
               digits <= ALL_BLANK;
               hold   <= '0;
               state  <= CNT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_disp_sched.sv
// Directed bench for disp_sched with SCAN_DIV=4, MSG_HOLD=3, GAP_TICKS=2.
// cyc counts rising edges since reset release; with SCAN_DIV=4 the tick is
// consumed at edges 4k and a frame boundary is consumed at edges 16k.
module tb_disp_sched;
   localparam int SD = 4, MH = 3, GT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] cnt_val = 16'h0;
   logic [15:0] msg_data = 16'h0;
   logic        msg_req = 1'b0;
   logic        msg_ack, scan_tick;
   logic [3:0]  d4, d3, d2, d1;
   logic [15:0] dig;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          acks = 0;

   assign dig = {d4, d3, d2, d1};

   disp_sched #(.SCAN_DIV(SD), .MSG_HOLD(MH), .GAP_TICKS(GT)) dut (
      .clk(clk), .rst(rst), .cnt_val(cnt_val), .msg_req(msg_req),
      .msg_data(msg_data), .msg_ack(msg_ack), .scan_tick(scan_tick),
      .d4(d4), .d3(d3), .d2(d2), .d1(d1)
   );

`ifdef DISP_BLINK_EN
   logic        bReq = 1'b0;
   logic        bAck, bTick;
   logic [3:0]  b4, b3, b2, b1;
   logic [15:0] bdig;
   assign bdig = {b4, b3, b2, b1};

   disp_sched #(.SCAN_DIV(SD), .MSG_HOLD(128), .GAP_TICKS(GT)) u_blk (
      .clk(clk), .rst(rst), .cnt_val(cnt_val), .msg_req(bReq),
      .msg_data(msg_data), .msg_ack(bAck), .scan_tick(bTick),
      .d4(b4), .d3(b3), .d2(b2), .d1(b1)
   );
`endif

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   always @(negedge clk) if (msg_ack === 1'b1) acks <= acks + 1;

   // advance to the falling edge after rising edge n
   task automatic goto(input int n);
      int guard = 0;
      while (cyc < n && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
   endtask

   task automatic test_reset;
      #1 rst = 1'b1;
      #12;
      checks++; if (dig !== 16'hFFFF) begin errors++; $display("FAIL rst_digits: got %h want FFFF", dig); end
      checks++; if (msg_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b want 0", msg_ack); end
      checks++; if (scan_tick !== 1'b0) begin errors++; $display("FAIL rst_tick: got %b want 0", scan_tick); end
      @(negedge clk);
      rst = 1'b0;
      cnt_val = 16'h0042;
      goto(2);
      checks++; if (scan_tick !== 1'b0) begin errors++; $display("FAIL early_tick: got %b want 0", scan_tick); end
      goto(3);
      checks++; if (scan_tick !== 1'b1) begin errors++; $display("FAIL first_tick: got %b want 1", scan_tick); end
      goto(4);
      checks++; if (scan_tick !== 1'b0) begin errors++; $display("FAIL tick_width: got %b want 0", scan_tick); end
      goto(15);
      checks++; if (dig !== 16'hFFFF) begin errors++; $display("FAIL pre_frame: got %h want FFFF", dig); end
      goto(16);
      checks++; if (dig !== 16'hFF42) begin errors++; $display("FAIL first_count: got %h want FF42", dig); end
   endtask

   task automatic test_count;
      logic [15:0] vals [4] = '{16'h0000, 16'h1005, 16'h0A07, 16'h0900};
      logic [15:0] exps [4] = '{16'hFFF0, 16'h1005, 16'hFA07, 16'hF900};
      logic [15:0] prev;
      prev = 16'hFF42;
      for (int i = 0; i < 4; i++) begin
         cnt_val = vals[i];
         goto(32 + 16 * i - 1);
         checks++; if (dig !== prev) begin errors++; $display("FAIL count_hold%0d: got %h want %h", i, dig, prev); end
         goto(32 + 16 * i);
         checks++; if (dig !== exps[i]) begin errors++; $display("FAIL count_load%0d: got %h want %h", i, dig, exps[i]); end
         prev = exps[i];
      end
   endtask

   task automatic test_message;
      int a0;
      cnt_val = 16'h0123;
      msg_data = 16'hEABE;
      msg_req = 1'b1;
      a0 = acks;
      goto(81);
      msg_req = 1'b0;
      checks++; if (msg_ack !== 1'b1) begin errors++; $display("FAIL msg_ack: got %b want 1", msg_ack); end
      checks++; if (dig !== 16'hEABE) begin errors++; $display("FAIL msg_digits: got %h want EABE", dig); end
      goto(82);
      checks++; if (msg_ack !== 1'b0) begin errors++; $display("FAIL msg_ack_drop: got %b want 0", msg_ack); end
      goto(91);
      checks++; if (dig !== 16'hEABE) begin errors++; $display("FAIL msg_last: got %h want EABE", dig); end
      goto(92);
      checks++; if (dig !== 16'hFFFF) begin errors++; $display("FAIL gap_start: got %h want FFFF", dig); end
      goto(99);
      checks++; if (dig !== 16'hFFFF) begin errors++; $display("FAIL gap_end: got %h want FFFF", dig); end
      goto(100);
      checks++; if (dig !== 16'hF123) begin errors++; $display("FAIL gap_reload: got %h want F123", dig); end
      checks++; if (acks - a0 !== 1) begin errors++; $display("FAIL msg_ack_count: got %0d want 1", acks - a0); end
   endtask

   task automatic test_held_req;
      int a0;
      a0 = acks;
      msg_data = 16'hDEAD;
      msg_req = 1'b1;
      goto(101);
      checks++; if (msg_ack !== 1'b1) begin errors++; $display("FAIL held_ack1: got %b want 1", msg_ack); end
      goto(120);
      checks++; if (dig !== 16'hF123) begin errors++; $display("FAIL held_return: got %h want F123", dig); end
      checks++; if (acks - a0 !== 1) begin errors++; $display("FAIL held_ignored: got %0d acks want 1", acks - a0); end
      goto(121);
      msg_req = 1'b0;
      checks++; if (msg_ack !== 1'b1) begin errors++; $display("FAIL held_ack2: got %b want 1", msg_ack); end
      checks++; if (dig !== 16'hDEAD) begin errors++; $display("FAIL held_relatch: got %h want DEAD", dig); end
      goto(122);
      checks++; if (msg_ack !== 1'b0) begin errors++; $display("FAIL held_ack2_drop: got %b want 0", msg_ack); end
   endtask

   task automatic test_frame_collision;
      cnt_val = 16'h0777;
      goto(140);
      checks++; if (dig !== 16'hF777) begin errors++; $display("FAIL coll_pre: got %h want F777", dig); end
      goto(143);
      msg_data = 16'hFCBA;
      msg_req = 1'b1;
      goto(144);
      msg_req = 1'b0;
      checks++; if (msg_ack !== 1'b1) begin errors++; $display("FAIL coll_ack: got %b want 1", msg_ack); end
      checks++; if (dig !== 16'hFCBA) begin errors++; $display("FAIL coll_msg: got %h want FCBA", dig); end
      goto(155);
      checks++; if (dig !== 16'hFCBA) begin errors++; $display("FAIL coll_hold: got %h want FCBA", dig); end
      goto(164);
      checks++; if (dig !== 16'hF777) begin errors++; $display("FAIL coll_return: got %h want F777", dig); end
   endtask

   task automatic test_reset_mid_msg;
      int a0;
      cnt_val = 16'h0042;
      goto(165);
      msg_data = 16'hEEEE;
      msg_req = 1'b1;
      goto(166);
      msg_req = 1'b0;
      checks++; if (dig !== 16'hEEEE) begin errors++; $display("FAIL mid_msg: got %h want EEEE", dig); end
      goto(169);
      a0 = acks;
      rst = 1'b1;
      #1;
      checks++; if (dig !== 16'hFFFF) begin errors++; $display("FAIL mid_rst_digits: got %h want FFFF", dig); end
      checks++; if (msg_ack !== 1'b0) begin errors++; $display("FAIL mid_rst_ack: got %b want 0", msg_ack); end
      checks++; if (scan_tick !== 1'b0) begin errors++; $display("FAIL mid_rst_tick: got %b want 0", scan_tick); end
      @(negedge clk);
      rst = 1'b0;
      goto(3);
      checks++; if (scan_tick !== 1'b1) begin errors++; $display("FAIL mid_rst_presc: got %b want 1", scan_tick); end
      goto(15);
      checks++; if (dig !== 16'hFFFF) begin errors++; $display("FAIL mid_rst_blank: got %h want FFFF", dig); end
      goto(16);
      checks++; if (dig !== 16'hFF42) begin errors++; $display("FAIL mid_rst_cnt: got %h want FF42", dig); end
      checks++; if (acks !== a0) begin errors++; $display("FAIL mid_rst_noack: got %0d acks want %0d", acks, a0); end
   endtask

`ifdef DISP_BLINK_EN
   // accept at edge 17; ticks consumed at 20, 24, ... so tick 32 is edge 144
   task automatic test_blink;
      msg_data = 16'h1234;
      bReq = 1'b1;
      goto(17);
      bReq = 1'b0;
      checks++; if (bdig !== 16'h1234) begin errors++; $display("FAIL blink_first: got %h want 1234", bdig); end
      goto(143);
      checks++; if (bdig !== 16'h1234) begin errors++; $display("FAIL blink_on_end: got %h want 1234", bdig); end
      goto(144);
      checks++; if (bdig !== 16'hFFFF) begin errors++; $display("FAIL blink_off: got %h want FFFF", bdig); end
      goto(271);
      checks++; if (bdig !== 16'hFFFF) begin errors++; $display("FAIL blink_off_end: got %h want FFFF", bdig); end
      goto(272);
      checks++; if (bdig !== 16'h1234) begin errors++; $display("FAIL blink_on2: got %h want 1234", bdig); end
   endtask
`endif

   initial begin
      test_reset();
      test_count();
      test_message();
      test_held_req();
      test_frame_collision();
      test_reset_mid_msg();
`ifdef DISP_BLINK_EN
      test_blink();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
